// File: rtl/riscv_tag_mode_pipe.sv
// Tag-propagation mode decoder for the DIFT RI5CY ID stage: private lockable TPR copy,
// instruction classification, one-stage valid/ready output register and a non-default-mode counter.
module riscv_tag_mode_pipe #(
  parameter int unsigned          MODE_WIDTH = 2,
  parameter int unsigned          TPR_WIDTH  = 32,
  parameter logic [TPR_WIDTH-1:0] TPR_RESET  = '0,
  parameter int unsigned          CNT_WIDTH  = 16,
  parameter logic [6:0]           SET_OPCODE = 7'h0B
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_valid_i,
  output logic                  instr_ready_o,
  input  logic [31:0]           instr_rdata_i,
  input  logic                  tpr_we_i,
  input  logic [TPR_WIDTH-1:0]  tpr_wdata_i,
  input  logic                  tpr_lock_i,
  output logic [TPR_WIDTH-1:0]  tpr_o,
  output logic                  mode_valid_o,
  input  logic                  mode_ready_i,
  output logic [MODE_WIDTH-1:0] alu_operator_o_mode,
  output logic                  register_set_o,
  output logic [2:0]            tag_class_o,
  output logic                  tpr_err_o,
  output logic                  tpr_locked_o,
  output logic [CNT_WIDTH-1:0]  active_cnt_o,
  input  logic                  cnt_clr_i
);

  if (TPR_WIDTH < 8 * MODE_WIDTH) begin : g_tpr_too_narrow
    $error("TPR_WIDTH must hold eight MODE_WIDTH fields");
  end

  typedef enum logic [2:0] {
    CLS_LOADSTORE  = 3'd0,
    CLS_LOGICAL    = 3'd1,
    CLS_COMPARISON = 3'd2,
    CLS_SHIFT      = 3'd3,
    CLS_JUMP       = 3'd4,
    CLS_INTEGER    = 3'd5,
    CLS_BRANCH     = 3'd6,
    CLS_NONE       = 3'd7
  } tag_class_e;

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  logic [TPR_WIDTH-1:0]  tpr_q;
  lock_state_e           lock_state;
  logic                  tpr_wr;
  logic [TPR_WIDTH-1:0]  tpr_eff;
  logic                  accept;
  tag_class_e            cls;
  logic                  force_zero;
  logic                  set_instr;
  logic [MODE_WIDTH-1:0] mode;

  wire [6:0] opcode = instr_rdata_i[6:0];
  wire [2:0] f3     = instr_rdata_i[14:12];
  wire [6:0] f7     = instr_rdata_i[31:25];
  wire       unused_instr = ^{instr_rdata_i[24:15], instr_rdata_i[11:7]};

  assign tpr_wr        = tpr_we_i && (lock_state == UNLOCKED);
  // A TPR write landing in the same cycle as an accept must steer that instruction's mode.
  assign tpr_eff       = tpr_wr ? tpr_wdata_i : tpr_q;
  assign instr_ready_o = !mode_valid_o || mode_ready_i;
  assign accept        = instr_valid_i && instr_ready_o;

  if (TPR_WIDTH > 8 * MODE_WIDTH) begin : g_tpr_spare
    wire unused_tpr = ^tpr_eff[TPR_WIDTH-1:8*MODE_WIDTH];
  end

  // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
  always_comb begin
    cls        = CLS_NONE;
    force_zero = 1'b0;
    set_instr  = 1'b0;
    if (opcode == SET_OPCODE && f7 == 7'b1111010) begin
      set_instr = 1'b1;
    end else begin
      case (opcode)
        OPC_JAL, OPC_JALR:           cls = CLS_JUMP;
        OPC_BRANCH:                  cls = CLS_BRANCH;
        OPC_STORE, OPC_LUI, OPC_AUIPC: cls = CLS_LOADSTORE;
        OPC_LOAD: begin
          cls        = CLS_LOADSTORE;
          force_zero = 1'b1;
        end
        OPC_OPIMM: begin
          case (f3)
            3'b000:                 cls = CLS_INTEGER;
            3'b010, 3'b011:         cls = CLS_COMPARISON;
            3'b100, 3'b110, 3'b111: cls = CLS_LOGICAL;
            3'b001: if (f7 == 7'b0000000) cls = CLS_SHIFT;
            3'b101: if (f7 == 7'b0000000 || f7 == 7'b0100000) cls = CLS_SHIFT;
            default:                cls = CLS_NONE;
          endcase
        end
        OPC_OP: begin
          if (f7 == 7'b0000001) begin
            cls = CLS_INTEGER;
          end else if (f7 == 7'b0000000) begin
            case (f3)
              3'b000:                 cls = CLS_INTEGER;
              3'b001, 3'b101:         cls = CLS_SHIFT;
              3'b010, 3'b011:         cls = CLS_COMPARISON;
              default:                cls = CLS_LOGICAL;
            endcase
          end else if (f7 == 7'b0100000) begin
            if (f3 == 3'b000)      cls = CLS_INTEGER;
            else if (f3 == 3'b101) cls = CLS_SHIFT;
          end
        end
        default: cls = CLS_NONE;
      endcase
    end
  end

  // Class NONE never selects a field, so its TPR slot is ignored.
  always_comb begin
    mode = '0;
    for (int k = 0; k < 7; k++) begin
      if (cls == k[2:0] && !force_zero) mode = tpr_eff[k*MODE_WIDTH +: MODE_WIDTH];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_state <= UNLOCKED;
      tpr_q      <= TPR_RESET;
      tpr_err_o  <= 1'b0;
    end else begin
      if (tpr_wr) tpr_q <= tpr_wdata_i;
      tpr_err_o <= tpr_we_i && (lock_state == LOCKED);
      case (lock_state)
        UNLOCKED: if (tpr_lock_i) lock_state <= LOCKED;
        default:  lock_state <= LOCKED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_valid_o        <= 1'b0;
      alu_operator_o_mode <= '0;
      register_set_o      <= 1'b0;
      tag_class_o         <= 3'd0;
    end else if (accept) begin
      mode_valid_o        <= 1'b1;
      alu_operator_o_mode <= mode;
      register_set_o      <= set_instr;
      tag_class_o         <= cls;
    end else if (mode_ready_i) begin
      mode_valid_o        <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr_i) begin
      active_cnt_o <= '0;
    end else if (accept && mode != '0 && active_cnt_o != '1) begin
      active_cnt_o <= active_cnt_o + 1'b1;
    end
  end

  assign tpr_o        = tpr_q;
  assign tpr_locked_o = (lock_state == LOCKED);

endmodule

// File: doc/riscv_tag_mode_pipe.md
Name: riscv_tag_mode_pipe

Overview:
Parametrised, pipelined successor to the combinational mode decoder in the ID stage of the DIFT RI5CY core. It holds a private copy of the Tag Propagation Register (TPR) with a lockable write port, and classifies each instruction into a tag-propagation class. It extracts a MODE_WIDTH-bit mode for that class and delivers it to EX through a one-stage valid/ready register. It also counts instructions that propagate tags in a non-default mode.

Parameters:
MODE_WIDTH, 2, width of each per-class mode field and of the mode output
TPR_WIDTH, 32, TPR width; must be >= 8*MODE_WIDTH (elaboration assertion)
TPR_RESET, 0, TPR value after reset
CNT_WIDTH, 16, width of the non-default-mode counter
SET_OPCODE, 7'h0B, opcode of the tag-set instruction

Ports:
clk  in  1  core clock
rst_n  in  1  reset, synchronous, active-low
instr_valid_i  in  1  instruction word valid from IF/ID
instr_ready_o  out  1  block can accept an instruction this cycle
instr_rdata_i  in  32  instruction word
tpr_we_i  in  1  TPR write strobe from CSR unit
tpr_wdata_i  in  TPR_WIDTH  TPR write data
tpr_lock_i  in  1  lock TPR against further writes until reset
tpr_o  out  TPR_WIDTH  current TPR contents
mode_valid_o  out  1  output register holds a decoded instruction
mode_ready_i  in  1  EX consumes the output
alu_operator_o_mode  out  MODE_WIDTH  selected propagation mode
register_set_o  out  1  instruction is the tag-set instruction
tag_class_o  out  3  class index of the instruction
tpr_err_o  out  1  one-cycle pulse: write attempted while locked
tpr_locked_o  out  1  lock FSM state
active_cnt_o  out  CNT_WIDTH  count of accepted instructions with mode != 0
cnt_clr_i  in  1  synchronous clear of active_cnt_o

Behaviour:
- Reset (rst_n=0 at a clk edge): tpr=TPR_RESET; mode_valid_o=0; alu_operator_o_mode=0; register_set_o=0; tag_class_o=0; tpr_err_o=0; tpr_locked_o=0; active_cnt_o=0. Reset mid-transfer drops the held instruction.
- Class k occupies tpr[k*MODE_WIDTH +: MODE_WIDTH]. Classes: 0 LOADSTORE, 1 LOGICAL, 2 COMPARISON, 3 SHIFT, 4 JUMP, 5 INTEGER, 6 BRANCH, 7 NONE. Class 7 always yields mode 0.
- Class map:
  - JAL/JALR -> 4.
  - BRANCH -> 6.
  - STORE/LUI/AUIPC -> 0.
  - LOAD -> class 0 with mode forced to 0.
  - OPIMM: f3=000 -> 5; 010/011 -> 2; 100/110/111 -> 1; 001 with f7=0000000 -> 3; 101 with f7 in {0000000,0100000} -> 3.
  - OP with f7=0000001 (M extension, any f3) -> 5.
  - OP with f7=0000000: f3 000 -> 5, 001 -> 3, 010/011 -> 2, 100/110/111 -> 1, 101 -> 3.
  - OP with f7=0100000: f3 000 -> 5, 101 -> 3.
  - SET_OPCODE with f7=1111010 -> class 7, register_set=1.
  - Anything else -> class 7.
- Handshake:
  - instr_ready_o = !mode_valid_o || mode_ready_i (combinational).
  - Accept = instr_valid_i && instr_ready_o. On accept, the output register loads the decode at the next edge, giving latency 1 cycle.
  - mode_ready_i && !accept clears mode_valid_o.
  - While mode_valid_o && !mode_ready_i, all outputs stay stable.
  - Full throughput of 1 instruction per cycle.
- TPR write:
  - Accepted when tpr_we_i && !tpr_locked_o. tpr updates at the next edge.
  - An instruction accepted in the same cycle decodes with tpr_wdata_i (bypass).
- Lock FSM: UNLOCKED -> LOCKED on tpr_lock_i. LOCKED is left only by reset.
  - tpr_we_i and tpr_lock_i together in UNLOCKED: the write takes effect, then the FSM locks.
  - tpr_we_i in LOCKED: write ignored; tpr_err_o=1 in the next cycle only.
- Counter:
  - Increments on accept when the decoded mode != 0. Saturates at all-ones, with no wrap.
  - cnt_clr_i has priority over an increment in the same cycle; the result is 0.

Test Plan:
- Reset, tpr_wdata_i=32'h00000C00 written -> tpr_o=32'h00000C00. ADD 32'h003100B3 accepted -> next cycle mode_valid_o=1, tag_class_o=5, alu_operator_o_mode=2'b11, active_cnt_o=1.
- Hold mode_ready_i=0 with 3 back-to-back instrs (ADD, LW 32'h0000A083, BEQ 32'h00208063) -> instr_ready_o=0 after the first; ADD output held stable. Release -> 1/cycle in order; classes 5, 0 (mode 0), 6.
- Same-cycle tpr write 32'h00003000 plus BEQ accept -> output mode 2'b11 (bypass). Next cycle tpr_o=32'h00003000.
- tpr_lock_i=1, then write 32'hFFFFFFFF -> tpr_o unchanged, tpr_err_o pulses high for exactly 1 cycle, tpr_locked_o=1. Reset -> unlocked, tpr_o=TPR_RESET.
- Instr 32'hF400000B -> register_set_o=1, tag_class_o=7, mode 0, counter unchanged. Unknown opcode 32'h0000007F -> class 7, mode 0.
- CNT_WIDTH=2, 5 non-zero-mode accepts -> active_cnt_o saturates at 3. cnt_clr_i together with an accept -> 0.
